// File: rtl/arbitro_vc_ponderado_if.sv
// Bundle between the VC FIFOs, the weighted VC arbiter and the D0/D1 output FIFOs.
// The arbiter uses the slave side; the producer/consumer environment uses the master side.
interface arbitro_vc_ponderado_if #(
    parameter int unsigned DATA_W = 6
);
    logic [DATA_W-1:0] VC0;
    logic [DATA_W-1:0] VC1;
    logic              VC0_empty;
    logic              VC1_empty;
    logic              D0_almost_full;
    logic              D1_almost_full;
    logic              VC0_pop;
    logic              VC1_pop;
    logic [DATA_W-1:0] D0;
    logic [DATA_W-1:0] D1;
    logic              D0_push;
    logic              D1_push;
    logic              owner;

    modport master (
        output VC0, VC1, VC0_empty, VC1_empty, D0_almost_full, D1_almost_full,
        input  VC0_pop, VC1_pop, D0, D1, D0_push, D1_push, owner
    );

    modport slave (
        input  VC0, VC1, VC0_empty, VC1_empty, D0_almost_full, D1_almost_full,
        output VC0_pop, VC1_pop, D0, D1, D0_push, D1_push, owner
    );
endinterface

// File: rtl/arbitro_vc_ponderado.sv
// Weighted round-robin pop scheduler for VC0/VC1; routes each popped word by its
// destination bit into D0 or D1 one cycle later, never popping into an almost-full FIFO.
module arbitro_vc_ponderado #(
    parameter int unsigned DATA_W     = 6,
    parameter int unsigned DEST_BIT   = 4,
    parameter int unsigned WEIGHT_VC0 = 3,
    parameter int unsigned WEIGHT_VC1 = 1
) (
    input  logic                   clk,
    input  logic                   reset_L,
    arbitro_vc_ponderado_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] W_VC0 = CNT_W'(WEIGHT_VC0);
    localparam logic [CNT_W-1:0] W_VC1 = CNT_W'(WEIGHT_VC1);

    typedef enum logic {
        SERVE_VC0 = 1'b0,
        SERVE_VC1 = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] d0_q, d0_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    logic              d0_push_q, d0_push_d;
    logic              d1_push_q, d1_push_d;

    logic              elig0, elig1;
    logic              owner_bit, owner_elig, other_elig;
    logic              grant, sel;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  w_own, w_oth, cnt_inc;

    // Eligibility and grant: owner first, the other VC only when the owner cannot go.
    always_comb begin
        elig0      = !bus.VC0_empty &&
                     !(bus.VC0[DEST_BIT] ? bus.D1_almost_full : bus.D0_almost_full);
        elig1      = !bus.VC1_empty &&
                     !(bus.VC1[DEST_BIT] ? bus.D1_almost_full : bus.D0_almost_full);
        owner_bit  = (state_q == SERVE_VC1);
        owner_elig = owner_bit ? elig1 : elig0;
        other_elig = owner_bit ? elig0 : elig1;
        grant      = 1'b0;
        sel        = owner_bit;
        if (owner_elig) begin
            grant = 1'b1;
            sel   = owner_bit;
        end else if (other_elig) begin
            grant = 1'b1;
            sel   = !owner_bit;
        end
        word = sel ? bus.VC1 : bus.VC0;
    end

    assign bus.VC0_pop = reset_L && grant && !sel;
    assign bus.VC1_pop = reset_L && grant &&  sel;

    // Burst accounting and output routing for the next edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        w_own     = owner_bit ? W_VC1 : W_VC0;
        w_oth     = owner_bit ? W_VC0 : W_VC1;
        cnt_inc   = cnt_q + CNT_W'(1);

        if (grant) begin
            if (sel == owner_bit) begin
                if (cnt_inc == w_own) begin
                    state_d = (state_q == SERVE_VC0) ? SERVE_VC1 : SERVE_VC0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end else if (w_oth == CNT_W'(1)) begin
                // A single-grant burst by the other VC is already exhausted.
                cnt_d   = '0;
            end else begin
                state_d = (state_q == SERVE_VC0) ? SERVE_VC1 : SERVE_VC0;
                cnt_d   = CNT_W'(1);
            end

            if (word[DEST_BIT]) begin
                d1_d      = word;
                d1_push_d = 1'b1;
            end else begin
                d0_d      = word;
                d0_push_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SERVE_VC0;
            cnt_q     <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
        end
    end

    assign bus.D0      = d0_q;
    assign bus.D1      = d1_q;
    assign bus.D0_push = d0_push_q;
    assign bus.D1_push = d1_push_q;
    assign bus.owner   = (state_q == SERVE_VC1);
endmodule

// File: tb/tb_arbitro_vc_ponderado.sv
// Scoreboard bench for arbitro_vc_ponderado: behavioural VC FIFOs and arbiter model,
// expected pushes queued at pop time and matched when D0/D1 push appears.
module tb_arbitro_vc_ponderado;
    localparam int unsigned DATA_W = 6;
    localparam int unsigned DB     = 4;
    localparam int unsigned WT0    = 3;
    localparam int unsigned WT1    = 1;

    typedef struct {
        logic              dest;
        logic [DATA_W-1:0] word;
        int                due;
    } exp_t;

    logic clk;
    logic reset_L;

    arbitro_vc_ponderado_if #(.DATA_W(DATA_W)) bus ();

    arbitro_vc_ponderado #(
        .DATA_W(DATA_W), .DEST_BIT(DB), .WEIGHT_VC0(WT0), .WEIGHT_VC1(WT1)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] vc0_fifo[$];
    logic [DATA_W-1:0] vc1_fifo[$];
    exp_t              exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic              m_owner;
    int                m_cnt;
    logic [DATA_W-1:0] m_d0, m_d1;
    logic [7:0]        pat;
    int                pat_idx;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    endtask

    task automatic drive_heads();
        bus.VC0       = (vc0_fifo.size() > 0) ? vc0_fifo[0] : '0;
        bus.VC1       = (vc1_fifo.size() > 0) ? vc1_fifo[0] : '0;
        bus.VC0_empty = (vc0_fifo.size() == 0);
        bus.VC1_empty = (vc1_fifo.size() == 0);
    endtask

    function automatic int weight_of(input logic vc);
        return vc ? WT1 : WT0;
    endfunction

    // Reset is asserted away from any edge; outputs must clear immediately.
    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk_eq("rst_vc0_pop", 32'(bus.VC0_pop), 32'd0);
        chk_eq("rst_vc1_pop", 32'(bus.VC1_pop), 32'd0);
        chk_eq("rst_d0_push", 32'(bus.D0_push), 32'd0);
        chk_eq("rst_d1_push", 32'(bus.D1_push), 32'd0);
        chk_eq("rst_d0",      32'(bus.D0),      32'd0);
        chk_eq("rst_d1",      32'(bus.D1),      32'd0);
        chk_eq("rst_owner",   32'(bus.owner),   32'd0);
        m_owner = 1'b0;
        m_cnt   = 0;
        m_d0    = '0;
        m_d1    = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        drive_heads();
    endtask

    // One clock: check outputs at negedge, advance the model, then consume popped heads.
    task automatic step();
        logic e0, e1, oe, xe, gv, gs, p0, p1;
        logic [DATA_W-1:0] w;
        exp_t ent;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ent = exp_q.pop_front();
            chk_eq("d0_push", 32'(bus.D0_push), 32'(!ent.dest));
            chk_eq("d1_push", 32'(bus.D1_push), 32'(ent.dest));
            if (ent.dest) m_d1 = ent.word;
            else          m_d0 = ent.word;
        end else begin
            chk_eq("d0_push_idle", 32'(bus.D0_push), 32'd0);
            chk_eq("d1_push_idle", 32'(bus.D1_push), 32'd0);
        end
        chk_eq("d0_data", 32'(bus.D0), 32'(m_d0));
        chk_eq("d1_data", 32'(bus.D1), 32'(m_d1));
        chk_eq("owner",   32'(bus.owner), 32'(m_owner));

        e0 = 1'b0;
        e1 = 1'b0;
        if (vc0_fifo.size() > 0) begin
            w  = vc0_fifo[0];
            e0 = !(w[DB] ? bus.D1_almost_full : bus.D0_almost_full);
        end
        if (vc1_fifo.size() > 0) begin
            w  = vc1_fifo[0];
            e1 = !(w[DB] ? bus.D1_almost_full : bus.D0_almost_full);
        end
        oe = m_owner ? e1 : e0;
        xe = m_owner ? e0 : e1;
        gv = oe || xe;
        gs = oe ? m_owner : !m_owner;

        chk_eq("vc0_pop", 32'(bus.VC0_pop), 32'(gv && !gs));
        chk_eq("vc1_pop", 32'(bus.VC1_pop), 32'(gv && gs));
        p0 = bus.VC0_pop;
        p1 = bus.VC1_pop;

        if (pat_idx < 8) begin
            pat[pat_idx] = gv && gs;
            pat_idx++;
        end

        if (gv) begin
            w        = gs ? vc1_fifo[0] : vc0_fifo[0];
            ent.dest = w[DB];
            ent.word = w;
            ent.due  = cyc + 1;
            exp_q.push_back(ent);
            if (gs == m_owner) begin
                m_cnt++;
                if (m_cnt == weight_of(m_owner)) begin
                    m_owner = !m_owner;
                    m_cnt   = 0;
                end
            end else if (weight_of(gs) == 1) begin
                m_cnt = 0;
            end else begin
                m_owner = gs;
                m_cnt   = 1;
            end
        end

        @(posedge clk);
        #1;
        if (p0 && vc0_fifo.size() > 0) void'(vc0_fifo.pop_front());
        if (p1 && vc1_fifo.size() > 0) void'(vc1_fifo.pop_front());
        drive_heads();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_L            = 1'b0;
        bus.D0_almost_full = 1'b0;
        bus.D1_almost_full = 1'b0;
        pat                = '0;
        pat_idx            = 8;

        // Reset with VC0 pending, then five D0-bound words with VC1 empty.
        for (int i = 0; i < 5; i++) vc0_fifo.push_back(6'(6'h20 + 6'(i)));
        drive_heads();
        do_reset();
        run(8);
        chk_eq("vc0_drained", 32'(vc0_fifo.size()), 32'd0);

        // Both VCs busy: weighted 3:1 pattern.
        do_reset();
        for (int i = 0; i < 8; i++) vc0_fifo.push_back(6'(i + 1));
        for (int i = 0; i < 4; i++) vc1_fifo.push_back(6'(6'h10 + 6'(i)));
        drive_heads();
        pat = '0;
        pat_idx = 0;
        run(8);
        chk_eq("wrr_pattern", 32'(pat), 32'h88);
        run(6);

        // Destination bit set routes to D1.
        vc0_fifo.push_back(6'b010101);
        drive_heads();
        run(3);
        chk_eq("d1_word", 32'(bus.D1), 32'h15);

        // Backpressure on D0, then on both, then D0 released.
        for (int i = 0; i < 3; i++) vc0_fifo.push_back(6'(6'h02 + 6'(i)));
        for (int i = 0; i < 6; i++) vc1_fifo.push_back(6'(6'h18 + 6'(i)));
        bus.D0_almost_full = 1'b1;
        drive_heads();
        run(3);
        chk_eq("vc0_held", 32'(vc0_fifo.size()), 32'd3);
        bus.D1_almost_full = 1'b1;
        run(3);
        chk_eq("vc1_held", 32'(vc1_fifo.size()), 32'd3);
        bus.D0_almost_full = 1'b0;
        run(4);
        bus.D1_almost_full = 1'b0;
        run(6);

        // Reset after the second grant of a VC0 burst restarts a full burst.
        do_reset();
        vc0_fifo.delete();
        vc1_fifo.delete();
        for (int i = 0; i < 8; i++) vc0_fifo.push_back(6'(6'h08 + 6'(i)));
        for (int i = 0; i < 4; i++) vc1_fifo.push_back(6'(6'h30 + 6'(i)));
        drive_heads();
        run(2);
        do_reset();
        pat = '0;
        pat_idx = 4;
        pat_idx = 0;
        run(4);
        chk_eq("burst_after_reset", 32'(pat[3:0]), 32'h8);
        pat_idx = 8;

        // Random traffic and backpressure.
        for (int i = 0; i < 200; i++) begin
            if (vc0_fifo.size() < 4 && $urandom_range(0, 1) == 1) vc0_fifo.push_back(6'($urandom));
            if (vc1_fifo.size() < 4 && $urandom_range(0, 2) == 0) vc1_fifo.push_back(6'($urandom));
            bus.D0_almost_full = ($urandom_range(0, 3) == 0);
            bus.D1_almost_full = ($urandom_range(0, 3) == 0);
            drive_heads();
            step();
        end
        bus.D0_almost_full = 1'b0;
        bus.D1_almost_full = 1'b0;
        run(12);
        chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
